// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way select stage: buffer state
// encodings and the select-width helper.
package mux_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Smallest w with 2**w >= n; n is at least 2 here, so w is never 0.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_stage_if.sv
// Valid/ready operand bus around mux_stage; the slave modport is the stage,
// the master modport is the upstream/downstream environment.
interface mux_stage_if
  import mux_pkg::*;
#(
  parameter int bitnum  = 32,
  parameter int ways    = 4,
  parameter int selbits = clog2(ways)
);

  logic [ways*bitnum-1:0] in_data;
  logic [selbits-1:0]     sel;
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic [bitnum-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   sel_err;

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/mux_stage_mux_n.sv
// Purely combinational N-way selector; an out-of-range select falls back to
// way 0 and raises oob.
module mux_n
  import mux_pkg::*;
#(
  parameter int bitnum  = 32,
  parameter int ways    = 4,
  parameter int selbits = clog2(ways)
) (
  input  logic [ways*bitnum-1:0] in_data,
  input  logic [selbits-1:0]     sel,
  output logic [bitnum-1:0]      out,
  output logic                   oob
);

  always_comb begin
    // NOTE: defaults first so every path assigns out/oob and no latch is inferred.
    out = in_data[bitnum-1:0];
    oob = (int'(sel) >= ways);
    for (int k = 1; k < ways; k++) begin
      if (sel == selbits'(k)) out = in_data[k*bitnum +: bitnum];
    end
  end

endmodule

// File: rtl/mux_stage.sv
// Registered N-way select with a two-entry skid buffer; in_ready comes
// straight from a flop so downstream ready never reaches upstream in one cycle.
module mux_stage
  import mux_pkg::*;
#(
  parameter int bitnum = 32,
  parameter int ways   = 4
) (
  input logic  clk,
  input logic  rst,
  mux_stage_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic [bitnum-1:0] main_q, skid_q;
  logic              in_ready_q, sel_err_q;

  logic [bitnum-1:0] sel_data;
  logic              sel_oob;
  logic              out_valid;
  logic              accept, consume;
  logic              load_main, load_skid, main_from_skid;

  mux_n #(
    .bitnum (bitnum),
    .ways   (ways)
  ) u_mux_n (
    .in_data (bus.in_data),
    .sel     (bus.sel),
    .out     (sel_data),
    .oob     (sel_oob)
  );

  assign out_valid = (state_q != ST_EMPTY);
  // A flush throws away any offer made in the same cycle.
  assign accept    = bus.in_valid & in_ready_q & ~bus.flush;
  assign consume   = out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          case ({accept, consume})
            2'b10: begin
              state_d   = ST_FULL;
              load_skid = 1'b1;
            end
            2'b11:   load_main = 1'b1;
            2'b01:   state_d   = ST_EMPTY;
            default: state_d   = ST_ONE;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so the only event is the head draining.
          if (consume) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      sel_err_q  <= accept & sel_oob;
      if (load_main)           main_q <= sel_data;
      else if (main_from_skid) main_q <= skid_q;
    end
  end

  // NOTE: skid data is qualified by state_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= sel_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;
  assign bus.out_valid = out_valid;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_stage.sv
// Drives a 4-way and a 3-way mux_stage with identical stimulus and compares
// both against a queue-based model of a two-deep registered buffer.
module tb_mux_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] d;
  logic [1:0]   sel;
  logic         in_valid, flush, out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_stage_if #(.bitnum(32), .ways(4)) bus4 ();
  mux_stage_if #(.bitnum(32), .ways(3)) bus3 ();

  assign bus4.in_data   = d;
  assign bus4.sel       = sel;
  assign bus4.in_valid  = in_valid;
  assign bus4.flush     = flush;
  assign bus4.out_ready = out_ready;
  assign bus3.in_data   = d[95:0];
  assign bus3.sel       = sel;
  assign bus3.in_valid  = in_valid;
  assign bus3.flush     = flush;
  assign bus3.out_ready = out_ready;

  mux_stage #(.bitnum(32), .ways(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_stage #(.bitnum(32), .ways(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Reference model: FIFO of capacity two, registered ready, held head value.
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  logic [31:0] hold4, hold3;
  logic        m_ready, m_err3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] way(input int k);
    return d[k*32 +: 32];
  endfunction

  task automatic model_edge();
    bit acc, cons;
    acc  = in_valid && m_ready && !flush;
    cons = (q4.size() > 0) && out_ready;
    if (rst) begin
      q4.delete(); q3.delete();
      m_ready = 1'b0; hold4 = '0; hold3 = '0; m_err3 = 1'b0;
    end else if (flush) begin
      q4.delete(); q3.delete();
      m_ready = 1'b1; m_err3 = 1'b0;
    end else begin
      if (cons) begin
        void'(q4.pop_front());
        void'(q3.pop_front());
      end
      if (acc) begin
        q4.push_back(way(int'(sel)));
        q3.push_back(sel == 2'd3 ? way(0) : way(int'(sel)));
      end
      m_err3  = acc && (sel == 2'd3);
      m_ready = (q4.size() < 2);
      if (q4.size() > 0) begin
        hold4 = q4[0];
        hold3 = q3[0];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("u4.out_valid", 32'(bus4.out_valid), 32'(q4.size() > 0));
    check("u4.in_ready",  32'(bus4.in_ready),  32'(m_ready));
    check("u4.out_data",  bus4.out_data,       hold4);
    check("u4.sel_err",   32'(bus4.sel_err),   32'd0);
    check("u3.out_valid", 32'(bus3.out_valid), 32'(q3.size() > 0));
    check("u3.in_ready",  32'(bus3.in_ready),  32'(m_ready));
    check("u3.out_data",  bus3.out_data,       hold3);
    check("u3.sel_err",   32'(bus3.sel_err),   32'(m_err3));
  endtask

  task automatic fixed_ops();
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h1111_1111 * (k + 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sel = 2'd0;
    m_ready = 1'b0; hold4 = '0; hold3 = '0; m_err3 = 1'b0;
    fixed_ops();

    // Reset, then first fill with sel=2.
    repeat (2) cycle();
    check("reset.out_data", bus4.out_data, 32'd0);
    rst = 1'b0; in_valid = 1'b1; sel = 2'd2;
    cycle();
    check("ready_after_reset", 32'(bus4.in_ready), 32'd1);
    cycle();
    check("first_data", bus4.out_data, 32'h3333_3333);

    // Streaming through every way.
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i);
      cycle();
    end

    // Back-pressure, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cycle();
    end
    check("bp.in_ready", 32'(bus4.in_ready), 32'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (3) cycle();

    // Fill to FULL, then flush with a simultaneous offer.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    repeat (3) cycle();
    flush = 1'b1; sel = 2'd3;
    cycle();
    check("flush.out_valid", 32'(bus4.out_valid), 32'd0);
    check("flush.in_ready",  32'(bus4.in_ready),  32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Out-of-range select on the 3-way stage, alone and under flush.
    in_valid = 1'b1; sel = 2'd3;
    cycle();
    check("oob.pulse", 32'(bus3.sel_err), 32'd1);
    check("oob.data",  bus3.out_data,     32'h1111_1111);
    in_valid = 1'b0;
    cycle();
    check("oob.one_cycle", 32'(bus3.sel_err), 32'd0);
    in_valid = 1'b1; flush = 1'b1;
    cycle();
    check("oob_flush.no_pulse", 32'(bus3.sel_err), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    cycle();

    // Reset while FULL.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("rst_full.out_data", bus4.out_data, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) d[k*32 +: 32] = $urandom;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_stage.md
# mux_stage

Registered, parametrised N-way select stage for the pipelined CPU datapath. It is the next generation of the plain 2:1 select. It picks one of `ways` operands with `sel`, captures the result into a two-entry skid buffer, and presents it downstream under a valid/ready handshake. Downstream stalls and pipeline flushes are absorbed without combinational ready paths. It is used wherever a forwarding or writeback select must sit on a stage boundary.

## Interface
Parameters:
- `bitnum`, 32, operand width in bits.
- `ways`, 4, number of selectable inputs, range 2..16.
- `selbits`, derived as ceil(log2(ways)), width of `sel`. Not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  ways*bitnum  packed operands; way k occupies bits [k*bitnum +: bitnum].
- `sel`  in  selbits  way select, sampled with `in_data` on accept.
- `in_valid`  in  1  upstream offers an operand set.
- `in_ready`  out  1  stage can accept; driven from a register only.
- `flush`  in  1  discard all buffered entries.
- `out_data`  out  bitnum  selected operand at the head of the buffer.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream consumes the head entry.
- `sel_err`  out  1  one-cycle pulse when an accepted `sel` is >= `ways`.

## Operation
- The input is accepted when `in_valid & in_ready`. The output is consumed when `out_valid & out_ready`.
- Selection: `sel` < `ways` picks way `sel`. When `sel` >= `ways`, way 0 is captured and `sel_err` pulses for one cycle; this case is only possible when `ways` is not a power of 2.
- Buffer: the main register holds the head and drives `out_data`. The skid register holds the second entry.
- States:
  - EMPTY: no entries.
  - ONE: main register valid.
  - FULL: main and skid registers both valid.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept without consume → FULL; the new entry goes to skid.
  - ONE + accept + consume → ONE; the new entry goes to main.
  - ONE + consume → EMPTY.
  - FULL + consume → ONE; skid moves to main.
  - FULL does not accept.
- `in_ready` is registered as next_state != FULL. It is therefore never combinationally dependent on `out_ready`.
- `flush` has priority over everything else:
  - Next state is EMPTY.
  - Any accept in the same cycle is discarded.
  - `sel_err` is suppressed.
  - `in_ready` is 1 in the next cycle.
- `out_data` holds its last value when `out_valid` = 0; it is not zeroed except by reset.
- When `out_valid` = 1 and `out_ready` = 0, `out_data` stays stable until it is consumed.

## Timing
- Reset (rst high at an edge), values in the following cycle:
  - state EMPTY
  - `out_valid` = 0
  - `out_data` = 0
  - `sel_err` = 0
  - `in_ready` = 0
- `in_ready` rises to 1 one cycle after `rst` deasserts.
- Reset asserted mid-operation drops all entries, with no partial output.
- Latency: data accepted at edge t appears on `out_data` with `out_valid` = 1 after edge t, when the buffer was EMPTY, or behind the existing head otherwise.
- Throughput: one entry per cycle when `out_ready` is held high.
- Back-pressure: after `out_ready` falls, at most one further entry is accepted, into skid. `in_ready` is 0 from the next cycle.
- `sel_err` is asserted in the cycle after the accept edge, aligned with that entry's capture.

## Structure
- Shared package `mux_pkg`:
  - state encodings `ST_EMPTY` = 2'd0, `ST_ONE` = 2'd1, `ST_FULL` = 2'd2.
  - a clog2 function for `selbits`.
- One sub-module, `mux_n`: the parametrised purely combinational N-way selector, with inputs `bitnum`, `ways`, `in_data`, `sel` and outputs `out`, `oob`. `mux_stage` instantiates it once ahead of the skid buffer.

## Test plan
- Reset and fill:
  - Stimulus: `rst` high for 2 cycles, then `ways` = 4, `bitnum` = 32, operands 0x11111111/0x22222222/0x33333333/0x44444444, `sel` = 2, `in_valid` = 1, `out_ready` = 1.
  - Required response: during reset `out_valid` = 0 and `out_data` = 0; `in_ready` = 1 one cycle after reset; 0x33333333 appears with `out_valid` one cycle after the accept.
- Streaming:
  - Stimulus: `sel` cycles 0,1,2,3 every cycle with `out_ready` = 1.
  - Required response: outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; `in_ready` stays 1.
- Back-pressure:
  - Stimulus: drop `out_ready` while streaming.
  - Required response: exactly one more entry is accepted and `in_ready` goes to 0; `out_data` holds; after `out_ready` rises, both entries drain in order and nothing is lost or duplicated.
- Flush in FULL with a simultaneous offer:
  - Stimulus: assert `flush` with `in_valid` = 1 while the buffer is FULL.
  - Required response: next cycle `out_valid` = 0 and `in_ready` = 1; the offered entry never appears.
- Out-of-range select:
  - Stimulus: `ways` = 3, `sel` = 3 accepted.
  - Required response: captures way 0 and `sel_err` pulses for exactly one cycle; with `flush` in the same cycle, there is no pulse and nothing is captured.
- Reset mid-stream:
  - Stimulus: assert `rst` while FULL.
  - Required response: next cycle `out_valid` = 0, `out_data` = 0, `in_ready` = 0; clean restart afterwards.
